// File: rtl/rv32_fetch_decode.sv
// Fetch/decode front end: word PC, built-in instruction ROM, bypassed 32x32 register file,
// control decode and immediate generation, with a sticky halt that freezes fetch.
module rv32_fetch_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  jump_pc,
    input  logic        should_jump,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] write_data,
    input  logic        in_reg_wrenable,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] imm,
    output logic [4:0]  out_write_reg,
    output logic        out_reg_wrenable,
    output logic [3:0]  jump_type,
    output logic        mem_wrenable,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [4:0]  alu_op,
    output logic [4:0]  pc
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_BEQ   = 5'd11;
    localparam logic [4:0] ALU_BNE   = 5'd12;
    localparam logic [4:0] ALU_BLT   = 5'd13;
    localparam logic [4:0] ALU_BGE   = 5'd14;
    localparam logic [4:0] ALU_BLTU  = 5'd15;
    localparam logic [4:0] ALU_BGEU  = 5'd16;

    logic        halted;
    logic        halt_decoded;
    logic [31:0] regs [32];
    logic [31:0] rom_word;
    logic [31:0] instr;

    always_comb begin
        unique case (pc)
            5'd0:    rom_word = 32'h0050_0093;
            5'd1:    rom_word = 32'h0070_0113;
            5'd2:    rom_word = 32'h0020_81B3;
            5'd3:    rom_word = 32'h0030_2023;
            5'd4:    rom_word = 32'h0000_2203;
            5'd5:    rom_word = 32'h0010_8463;
            5'd6:    rom_word = 32'h0000_0073;
            default: rom_word = NOP_INSTR;
        endcase
    end

    assign instr = halted ? NOP_INSTR : rom_word;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign alt           = instr[30];
    assign rs1           = instr[19:15];
    assign rs2           = instr[24:20];
    assign out_write_reg = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Register-register ops use funct7[5] to pick SUB; immediate ops only use it for SRAI.
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'd0:    arith_op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op = ALU_SLL;
            3'd2:    arith_op = ALU_SLT;
            3'd3:    arith_op = ALU_SLTU;
            3'd4:    arith_op = ALU_XOR;
            3'd5:    arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'd1:    branch_op = ALU_BNE;
            3'd4:    branch_op = ALU_BLT;
            3'd5:    branch_op = ALU_BGE;
            3'd6:    branch_op = ALU_BLTU;
            3'd7:    branch_op = ALU_BGEU;
            default: branch_op = ALU_BEQ;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no opcode path can infer a latch.
        out_reg_wrenable = 1'b0;
        jump_type        = 4'd0;
        mem_wrenable     = 1'b0;
        mem_to_reg       = 1'b0;
        alu_src          = 1'b0;
        alu_op           = ALU_ADD;
        imm              = 32'd0;
        halt_decoded     = 1'b0;
        case (opcode)
            OPC_OP: begin
                out_reg_wrenable = 1'b1;
                alu_op           = arith_op(funct3, alt, 1'b1);
            end
            OPC_OP_IMM: begin
                out_reg_wrenable = 1'b1;
                alu_src          = 1'b1;
                alu_op           = arith_op(funct3, alt, 1'b0);
                imm              = imm_i;
            end
            OPC_LOAD: begin
                out_reg_wrenable = 1'b1;
                mem_to_reg       = 1'b1;
                alu_src          = 1'b1;
                imm              = imm_i;
            end
            OPC_STORE: begin
                mem_wrenable = 1'b1;
                alu_src      = 1'b1;
                imm          = imm_s;
            end
            OPC_BRANCH: begin
                jump_type = 4'd1;
                alu_op    = branch_op(funct3);
                imm       = imm_b;
            end
            OPC_JAL: begin
                jump_type        = 4'd2;
                out_reg_wrenable = 1'b1;
                imm              = imm_j;
            end
            OPC_JALR: begin
                jump_type        = 4'd3;
                out_reg_wrenable = 1'b1;
                alu_src          = 1'b1;
                imm              = imm_i;
            end
            OPC_LUI: begin
                out_reg_wrenable = 1'b1;
                alu_src          = 1'b1;
                alu_op           = ALU_PASSB;
                imm              = imm_u;
            end
            OPC_SYSTEM: halt_decoded = 1'b1;
            default: ;
        endcase
    end

    // Same-cycle writeback is forwarded so decode never sees a stale operand.
    function automatic logic [31:0] read_port(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0)
            read_port = 32'd0;
        else if (in_reg_wrenable && in_write_reg == idx)
            read_port = write_data;
        else
            read_port = stored;
    endfunction

    assign read_data1 = read_port(rs1, regs[rs1]);
    assign read_data2 = read_port(rs2, regs[rs2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= 5'd0;
            halted <= 1'b0;
            // NOTE: the register file is cleared on reset, so it is built from flops, not a RAM macro.
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments keep every update based on pre-edge values.
            if (in_reg_wrenable && in_write_reg != 5'd0)
                regs[in_write_reg] <= write_data;
            halted <= halted | halt_decoded;
            if (!halted)
                pc <= should_jump ? jump_pc : pc + 5'd1;
        end
    end
endmodule

// File: tb/tb_rv32_fetch_decode.sv
// Randomized scoreboard bench for rv32_fetch_decode: a driver pushes expected decode/read
// results from an instruction-level model; a negedge monitor pops and compares.
module tb_rv32_fetch_decode;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  jump_pc;
    logic        should_jump;
    logic [4:0]  in_write_reg;
    logic [31:0] write_data;
    logic        in_reg_wrenable;
    logic [31:0] read_data1, read_data2, imm;
    logic [4:0]  out_write_reg;
    logic        out_reg_wrenable;
    logic [3:0]  jump_type;
    logic        mem_wrenable, mem_to_reg, alu_src;
    logic [4:0]  alu_op;
    logic [4:0]  pc;

    rv32_fetch_decode dut (
        .clk(clk), .reset(reset), .jump_pc(jump_pc), .should_jump(should_jump),
        .in_write_reg(in_write_reg), .write_data(write_data), .in_reg_wrenable(in_reg_wrenable),
        .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
        .out_write_reg(out_write_reg), .out_reg_wrenable(out_reg_wrenable),
        .jump_type(jump_type), .mem_wrenable(mem_wrenable), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .pc(pc)
    );

    always #5 clk = ~clk;

    // What each fetched instruction means, written from its assembly form.
    typedef struct packed {
        bit        wr, asrc, mwe, m2r, halt;
        bit [4:0]  aop;
        bit [31:0] imm;
        bit [4:0]  rd, rs1, rs2;
        bit [3:0]  jt;
    } dec_t;

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rd;
        logic        wr;
        logic [3:0]  jt;
        logic        mwe, m2r, asrc;
        logic [4:0]  aop;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    int          m_pc     = 0;
    bit          m_halted = 1'b0;
    logic [31:0] m_regs[32];

    function automatic dec_t dec_of(input int addr, input bit halted);
        dec_t d = '0;
        if (halted || addr >= 7) begin // addi x0,x0,0
            d.wr = 1; d.asrc = 1;
            return d;
        end
        case (addr)
            0: begin d.wr = 1; d.asrc = 1; d.imm = 5; d.rd = 1; d.rs2 = 5; end  // addi x1,x0,5
            1: begin d.wr = 1; d.asrc = 1; d.imm = 7; d.rd = 2; d.rs2 = 7; end  // addi x2,x0,7
            2: begin d.wr = 1; d.rd = 3; d.rs1 = 1; d.rs2 = 2; end              // add x3,x1,x2
            3: begin d.mwe = 1; d.asrc = 1; d.rs2 = 3; end                       // sw x3,0(x0)
            4: begin d.wr = 1; d.m2r = 1; d.asrc = 1; d.rd = 4; end              // lw x4,0(x0)
            5: begin d.jt = 1; d.aop = 11; d.imm = 8; d.rd = 8; d.rs1 = 1; d.rs2 = 1; end // beq x1,x1,+8
            default: d.halt = 1;                                                 // ecall
        endcase
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs, input bit we,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (rs == 0) return 32'd0;
        if (we && wr == rs) return wd;
        return m_regs[rs];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: drive inputs, optionally queue the expected outputs, then advance the model.
    task automatic step(input bit rst, input bit chk, input bit sj, input logic [4:0] jpc,
                        input bit we, input logic [4:0] wr, input logic [31:0] wd);
        dec_t d;
        exp_t e;
        reset = rst; should_jump = sj; jump_pc = jpc;
        in_reg_wrenable = we; in_write_reg = wr; write_data = wd;
        d = dec_of(m_pc, m_halted);
        if (chk) begin
            e.pc = m_pc[4:0]; e.imm = d.imm; e.rd = d.rd; e.wr = d.wr; e.jt = d.jt;
            e.mwe = d.mwe; e.m2r = d.m2r; e.asrc = d.asrc; e.aop = d.aop;
            e.rd1 = model_read(d.rs1, we, wr, wd);
            e.rd2 = model_read(d.rs2, we, wr, wd);
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_halted = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (we && wr != 0) m_regs[wr] = wd;
            if (!m_halted) m_pc = sj ? int'(jpc) : (m_pc + 1) % 32;
            if (d.halt) m_halted = 1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pc",               32'(pc),               32'(e.pc));
            check("read_data1",       read_data1,            e.rd1);
            check("read_data2",       read_data2,            e.rd2);
            check("imm",              imm,                   e.imm);
            check("out_write_reg",    32'(out_write_reg),    32'(e.rd));
            check("out_reg_wrenable", 32'(out_reg_wrenable), 32'(e.wr));
            check("jump_type",        32'(jump_type),        32'(e.jt));
            check("mem_wrenable",     32'(mem_wrenable),     32'(e.mwe));
            check("mem_to_reg",       32'(mem_to_reg),       32'(e.m2r));
            check("alu_src",          32'(alu_src),          32'(e.asrc));
            check("alu_op",           32'(alu_op),           32'(e.aop));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit          sj, we;
        logic [4:0]  jpc, wr;
        logic [31:0] wd;

        reset = 1; should_jump = 0; jump_pc = 0;
        in_reg_wrenable = 0; in_write_reg = 0; write_data = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);                    // reset state visible during reset
        step(0, 1, 0, 0, 0, 0, 0);                    // pc0 addi x1
        step(0, 1, 0, 0, 0, 0, 0);                    // pc1 addi x2
        step(0, 1, 0, 0, 1, 5'd1, 32'd5);             // pc2 add, x1 bypass
        step(0, 1, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);     // pc3 sw, write to x0 ignored
        step(0, 1, 0, 0, 0, 0, 0);                    // pc4 lw
        step(0, 1, 1, 5'd1, 0, 0, 0);                 // pc5 beq reads stored x1, jump to 1
        step(0, 1, 1, 5'd4, 0, 0, 0);                 // pc1 -> 4
        step(0, 1, 1, 5'd30, 0, 0, 0);                // pc4 -> 30
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);         // 30, 31, wrap to 0

        // Random jumps and writebacks; pc 6 is never entered here so fetch keeps running.
        repeat (300) begin
            sj = ($urandom_range(0, 3) == 0);
            do jpc = 5'($urandom_range(0, 31)); while (jpc == 5'd6);
            if (!m_halted && m_pc == 5) sj = 1;
            we = $urandom_range(0, 1) == 1;
            wr = 5'($urandom_range(0, 7));
            wd = $urandom;
            step(0, 1, sj, jpc, we, wr, wd);
        end

        // Halt: jump onto the ecall, then try to move a frozen pc.
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 5'd6, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);                    // ecall cycle, pc still advances
        repeat (8) begin
            jpc = 5'($urandom_range(0, 31));
            wd  = $urandom;
            step(0, 1, 1, jpc, 1, 5'd1, wd);          // jumps ignored, writes still land
        end

        // Reset while halted clears halt and registers; fetch resumes at 0.
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 0, 0, 0);

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
